// File: rtl/functw_pkg.sv
// Shared rate encodings, code widths and W(IM) tables for the G.726 FUNCTW scale-factor multiplier.
package functw_pkg;

  localparam logic [1:0] RATE_40K = 2'b00;
  localparam logic [1:0] RATE_32K = 2'b01;
  localparam logic [1:0] RATE_24K = 2'b10;
  localparam logic [1:0] RATE_16K = 2'b11;

  // Negative entries are stored as 12-bit two's complement (FF4=-12, FFC=-4, FEA=-22).
  localparam logic [11:0] W40_TAB [16] = '{
    12'd14, 12'd14, 12'd24, 12'd39, 12'd40, 12'd41, 12'd58, 12'd100,
    12'd141, 12'd179, 12'd219, 12'd280, 12'd358, 12'd440, 12'd529, 12'd696
  };
  localparam logic [11:0] W32_TAB [8] = '{
    12'hFF4, 12'd18, 12'd41, 12'd64, 12'd112, 12'd198, 12'd355, 12'd1122
  };
  localparam logic [11:0] W24_TAB [4] = '{12'hFFC, 12'd30, 12'd137, 12'd582};
  localparam logic [11:0] W16_TAB [2] = '{12'hFEA, 12'd439};

  function automatic logic [2:0] code_width(input logic [1:0] rate);
    case (rate)
      RATE_40K: code_width = 3'd5;
      RATE_32K: code_width = 3'd4;
      RATE_24K: code_width = 3'd3;
      default:  code_width = 3'd2;
    endcase
  endfunction

  function automatic logic [11:0] w_lookup(input logic [1:0] rate, input logic [3:0] im);
    case (rate)
      RATE_40K: w_lookup = W40_TAB[im];
      RATE_32K: w_lookup = W32_TAB[im[2:0]];
      RATE_24K: w_lookup = W24_TAB[im[1:0]];
      default:  w_lookup = W16_TAB[im[0]];
    endcase
  endfunction

endpackage

// File: rtl/functw_skid_fifo.sv
// Fall-through output FIFO: an empty FIFO passes the write side straight to the read side.
module functw_skid_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_valid_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [CNT_W-1:0] count_next_o
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty, push, pop;

  always_comb begin
    empty    = (count_q == '0);
    pop      = rd_ready_i && !empty;
    // A write that is consumed in the same cycle through the bypass is never stored.
    push     = wr_valid_i && !(empty && rd_ready_i);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    if (push) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_valid_o   = !empty || wr_valid_i;
  assign rd_data_o    = empty ? wr_data_i : mem_q[rd_ptr_q];
  assign count_next_o = count_d;

endmodule

// File: rtl/functw_mc.sv
// Multi-channel pipelined FUNCTW W(IM) lookup with per-channel RATE registers.
// Define FUNCTW_SKID_EN to decouple the pipeline from out_ready through an output skid FIFO.
module functw_mc
  import functw_pkg::*;
#(
  parameter int         NUM_CH     = 4,
  parameter int         CH_W       = 2,
  parameter logic [1:0] RESET_RATE = 2'b01
`ifdef FUNCTW_SKID_EN
  ,
  parameter int         SKID_DEPTH = 4
`endif
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cfg_we,
  input  logic [CH_W-1:0] cfg_ch,
  input  logic [1:0]      cfg_rate,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CH_W-1:0] in_ch,
  input  logic [4:0]      in_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CH_W-1:0] out_ch,
  output logic [3:0]      out_im,
  output logic [11:0]     out_wi
);
  localparam logic [CH_W:0] CH_LIM = (CH_W + 1)'(NUM_CH);

  logic [1:0]      rate_q [NUM_CH];
  logic            in_ch_ok, accept;
  logic [1:0]      in_rate;
  logic [5:0]      in_mask;
  logic [4:0]      in_code;

  logic            s1_adv, s2_adv;
  logic            s1_valid_q, s1_valid_d;
  logic [CH_W-1:0] s1_ch_q;
  logic [1:0]      s1_rate_q;
  logic [4:0]      s1_code_q;
  logic [2:0]      s1_n;
  logic [4:0]      s1_mag_mask;
  logic [3:0]      s1_im;

  logic            s2_valid_q;
  logic [CH_W-1:0] s2_ch_q;
  logic [3:0]      s2_im_q;
  logic [11:0]     s2_wi_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) rate_q[c] <= RESET_RATE;
    end else if (cfg_we && ({1'b0, cfg_ch} < CH_LIM)) begin
      rate_q[cfg_ch] <= cfg_rate;
    end
  end

  always_comb begin
    in_ch_ok = ({1'b0, in_ch} < CH_LIM);
    in_rate  = in_ch_ok ? rate_q[in_ch] : RESET_RATE;
    in_mask  = (6'd1 << code_width(in_rate)) - 6'd1;
    in_code  = in_i & in_mask[4:0];
    accept   = in_valid && in_ready;
    // Out-of-range channels are consumed but never enter the pipeline.
    s1_valid_d = s1_adv ? (accept && in_ch_ok) : s1_valid_q;
  end

  always_comb begin
    s1_n        = code_width(s1_rate_q);
    s1_mag_mask = (5'd1 << (s1_n - 3'd1)) - 5'd1;
    s1_im       = s1_code_q[s1_n - 3'd1] ? (~s1_code_q[3:0] & s1_mag_mask[3:0])
                                         : (s1_code_q[3:0] & s1_mag_mask[3:0]);
  end

  always_ff @(posedge clk) begin
    if (reset) s1_valid_q <= 1'b0;
    else       s1_valid_q <= s1_valid_d;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_ch_q   <= in_ch;
      s1_rate_q <= in_rate;
      s1_code_q <= in_code;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_q <= 1'b0;
      s2_ch_q    <= '0;
      s2_im_q    <= '0;
      s2_wi_q    <= '0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_ch_q <= s1_ch_q;
        s2_im_q <= s1_im;
        s2_wi_q <= w_lookup(s1_rate_q, s1_im);
      end
    end
  end

`ifdef FUNCTW_SKID_EN
  localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);

  logic                  in_ready_q;
  logic                  fifo_rd_valid;
  logic [SKID_CNT_W-1:0] fifo_cnt_next;
  int                    occ_next;

  assign s1_adv = 1'b1;
  assign s2_adv = 1'b1;

  // Items held after this edge: S1, S2 (fed from S1) and the FIFO.
  always_comb occ_next = int'(s1_valid_d) + int'(s1_valid_q) + int'(fifo_cnt_next);

  always_ff @(posedge clk) begin
    if (reset) in_ready_q <= 1'b1;
    else       in_ready_q <= (occ_next < SKID_DEPTH);
  end

  functw_skid_fifo #(
    .WIDTH (CH_W + 16),
    .DEPTH (SKID_DEPTH),
    .CNT_W (SKID_CNT_W)
  ) u_skid (
    .clk          (clk),
    .reset        (reset),
    .wr_valid_i   (s2_valid_q),
    .wr_data_i    ({s2_ch_q, s2_im_q, s2_wi_q}),
    .rd_valid_o   (fifo_rd_valid),
    .rd_ready_i   (out_ready),
    .rd_data_o    ({out_ch, out_im, out_wi}),
    .count_next_o (fifo_cnt_next)
  );

  assign in_ready  = in_ready_q && !reset;
  assign out_valid = fifo_rd_valid && !reset;
`else
  assign s2_adv    = !s2_valid_q || out_ready;
  assign s1_adv    = !s1_valid_q || s2_adv;
  assign in_ready  = s1_adv && !reset;
  assign out_valid = s2_valid_q && !reset;
  assign out_ch    = s2_ch_q;
  assign out_im    = s2_im_q;
  assign out_wi    = s2_wi_q;
`endif

endmodule

// File: tb/tb_functw_mc.sv
// Directed and exhaustive bench for functw_mc with a scoreboard of expected results.
module tb_functw_mc;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  logic            clk = 1'b0;
  logic            reset, cfg_we, in_valid, out_ready;
  logic [CH_W-1:0] cfg_ch, in_ch;
  logic [1:0]      cfg_rate;
  logic [4:0]      in_i;
  logic            in_ready, out_valid;
  logic [CH_W-1:0] out_ch;
  logic [3:0]      out_im;
  logic [11:0]     out_wi;

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic [3:0]      im;
    logic [11:0]     wi;
  } res_t;

  res_t       exp_q[$];
  int         checks = 0;
  int         failures = 0;
  logic [1:0] rate_m [NUM_CH];
  bit         prev_stall = 0;
  res_t       prev_out;
  bit         saw_not_ready = 0;

  int w40 [16] = '{14, 14, 24, 39, 40, 41, 58, 100, 141, 179, 219, 280, 358, 440, 529, 696};
  int w32 [8]  = '{-12, 18, 41, 64, 112, 198, 355, 1122};
  int w24 [4]  = '{-4, 30, 137, 582};
  int w16 [2]  = '{-22, 439};

  always #5 clk = ~clk;

  functw_mc dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_rate  (cfg_rate),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ch     (in_ch),
    .in_i      (in_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_im    (out_im),
    .out_wi    (out_wi)
  );

  function automatic res_t model(input logic [CH_W-1:0] ch, input logic [1:0] rate,
                                 input logic [4:0] code);
    int n, c, im, w;
    n  = 5 - int'(rate);
    c  = int'(code) & ((1 << n) - 1);
    im = (c >= (1 << (n - 1))) ? ((1 << n) - 1 - c) : c;
    case (rate)
      2'b00:   w = w40[im];
      2'b01:   w = w32[im];
      2'b10:   w = w24[im];
      default: w = w16[im];
    endcase
    return {ch, 4'(im), 12'(w)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // One clock: sample handshakes at negedge, update the scoreboard, return #1 after posedge.
  task automatic cyc(output bit acc);
    res_t o, e;
    @(negedge clk);
    acc = in_valid && in_ready;
    o   = {out_ch, out_im, out_wi};
    if (in_valid && !in_ready) saw_not_ready = 1;
    if (prev_stall) check("hold_while_stalled", o, prev_out);
    if (acc) exp_q.push_back(model(in_ch, rate_m[in_ch], in_i));
    if (out_valid && out_ready) begin
      check("sb_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("result", o, e);
      end
    end
    if (cfg_we) rate_m[cfg_ch] = cfg_rate;
    prev_stall = out_valid && !out_ready;
    prev_out   = o;
    if (reset) begin
      exp_q.delete();
      prev_stall = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int sent, t, tries, mask;
    reset = 1; cfg_we = 0; cfg_ch = 0; cfg_rate = 0;
    in_valid = 0; in_ch = 0; in_i = 0; out_ready = 1;
    for (int c = 0; c < NUM_CH; c++) rate_m[c] = 2'b01;

    // Reset state
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", {out_ch, out_im, out_wi}, 0);
    cyc(acc);
    reset = 0; #1;
    check("post_rst_in_ready", in_ready, 1);

    // 1: default 32k, code 01111 -> IM 0, W=-12, two cycles after accept
    in_valid = 1; in_ch = 0; in_i = 5'b01111;
    cyc(acc);
    in_valid = 0;
    check("t1_accepted", acc, 1);
    check("t1_lat1_out_valid", out_valid, 0);
    cyc(acc);
    check("t1_lat2_out_valid", out_valid, 1);
    check("t1_out", {out_ch, out_im, out_wi}, {2'd0, 4'd0, 12'hFF4});
    cyc(acc);

    // 2: per-channel rates, results on consecutive cycles
    cfg_we = 1; cfg_ch = 1; cfg_rate = 2'b00; cyc(acc);
    cfg_ch = 2; cfg_rate = 2'b10; cyc(acc);
    cfg_ch = 3; cfg_rate = 2'b11; cyc(acc);
    cfg_we = 0;
    in_valid = 1; in_ch = 1; in_i = 5'b10000; cyc(acc);
    in_ch = 2; in_i = 5'b00100; cyc(acc);
    check("t2_r0_valid", out_valid, 1);
    check("t2_r0", {out_ch, out_wi}, {2'd1, 12'd696});
    in_ch = 3; in_i = 5'b00001; cyc(acc);
    in_valid = 0;
    check("t2_r1_valid", out_valid, 1);
    check("t2_r1", {out_ch, out_wi}, {2'd2, 12'd582});
    cyc(acc);
    check("t2_r2_valid", out_valid, 1);
    check("t2_r2", {out_ch, out_wi}, {2'd3, 12'd439});
    cyc(acc);

    // 3: same-cycle cfg write does not affect the code accepted with it
    cfg_we = 1; cfg_ch = 0; cfg_rate = 2'b11;
    in_valid = 1; in_ch = 0; in_i = 5'b00011; cyc(acc);
    cfg_we = 0; cyc(acc);
    in_valid = 0;
    check("t3_old_rate", out_wi, 12'd64);
    cyc(acc);
    check("t3_new_rate", out_wi, 12'hFEA);
    cyc(acc);

    // 4: stream 8 codes with a 5-cycle downstream stall
    sent = 0; t = 0; saw_not_ready = 0;
    while (sent < 8 && t < 100) begin
      in_valid = 1; in_ch = 2'(sent % 4); in_i = 5'(sent * 3 + 1);
      out_ready = !(t >= 3 && t < 8);
      cyc(acc);
      if (acc) sent++;
      t++;
    end
    in_valid = 0; out_ready = 1;
    check("t4_sent", sent, 8);
    check("t4_in_ready_dropped", saw_not_ready, 1);
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) cyc(acc);
    check("t4_drained", exp_q.size(), 0);

    // 5: reset with two results in flight
    in_valid = 1; in_ch = 1; in_i = 5'b00111; cyc(acc);
    in_ch = 2; in_i = 5'b00010; cyc(acc);
    in_valid = 0; reset = 1; #1;
    check("t5_rst_out_valid", out_valid, 0);
    check("t5_rst_in_ready", in_ready, 0);
    cyc(acc);
    reset = 0; #1;
    check("t5_post_in_ready", in_ready, 1);
    for (int k = 0; k < 4; k++) begin
      check("t5_no_stale", out_valid, 0);
      cyc(acc);
    end

    // 6: every rate x code x channel, random high bits and random backpressure
    for (int ch = 0; ch < NUM_CH; ch++) begin
      for (int r = 0; r < 4; r++) begin
        cfg_we = 1; cfg_ch = 2'(ch); cfg_rate = 2'(r); in_valid = 0;
        cyc(acc);
        cfg_we = 0;
        mask = (1 << (5 - r)) - 1;
        for (int code = 0; code <= mask; code++) begin
          in_valid = 1; in_ch = 2'(ch);
          in_i = 5'((code & mask) | (int'($urandom_range(0, 31)) & ~mask));
          tries = 0;
          do begin
            out_ready = ($urandom_range(0, 7) != 0);
            cyc(acc);
            tries++;
          end while (!acc && tries < 50);
          if (!acc) check("t6_accept_timeout", acc, 1);
        end
      end
    end
    in_valid = 0; out_ready = 1;
    for (int k = 0; k < 50 && exp_q.size() > 0; k++) cyc(acc);
    check("t6_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
